// File: rtl/cbfp_denorm.sv
// Block-floating-point de-normalizer at the FFT output.
// Stage 1 registers each sample, its index sum and its frame position.
// Stage 2 applies the gain 2^(BIAS - total) with floor rounding and saturation,
// then tags the frame boundaries.
module cbfp_denorm #(
    parameter int WIDTH_IN  = 13,
    parameter int WIDTH_OUT = 23,
    parameter int IDX_W     = 6,
    parameter int BIAS      = 12,
    parameter int N         = 512
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        din_valid,
    input  logic signed [WIDTH_IN-1:0]  din_re,
    input  logic signed [WIDTH_IN-1:0]  din_im,
    input  logic        [IDX_W-1:0]     index1,
    input  logic        [IDX_W-1:0]     index2,
    output logic                        dout_valid,
    output logic signed [WIDTH_OUT-1:0] dout_re,
    output logic signed [WIDTH_OUT-1:0] dout_im,
    output logic                        dout_first,
    output logic                        dout_last,
    output logic                        frame_sat
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int WF    = WIDTH_IN + BIAS;
    // One spare bit above the widest operand keeps the saturation compare signed-safe.
    localparam int WW    = ((WF > WIDTH_OUT) ? WF : WIDTH_OUT) + 1;

    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(N - 1);
    localparam logic [IDX_W:0]        BIAS_T   = (IDX_W + 1)'(BIAS);
    localparam logic [IDX_W:0]        WIN_T    = (IDX_W + 1)'(WIDTH_IN);
    localparam logic signed [WW-1:0]  MAXV     = {{(WW - WIDTH_OUT + 1){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [WW-1:0]  MINV     = {{(WW - WIDTH_OUT + 1){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

    logic                       s1_valid;
    logic signed [WIDTH_IN-1:0] s1_re;
    logic signed [WIDTH_IN-1:0] s1_im;
    logic        [IDX_W:0]      s1_total;
    logic        [CNT_W-1:0]    s1_idx;
    logic        [CNT_W-1:0]    cnt;
    logic                       sticky;

    logic        [WIDTH_OUT:0]  re_res;
    logic        [WIDTH_OUT:0]  im_res;
    logic                       s1_last;
    logic                       sat_now;

    // Returns {saturated, value} for x * 2^(BIAS - total).
    function automatic logic [WIDTH_OUT:0] denorm(input logic signed [WIDTH_IN-1:0] x,
                                                   input logic [IDX_W:0] total);
        logic signed [WW-1:0] xs;
        logic signed [WW-1:0] wide;
        logic        [IDX_W:0] sh;
        logic                  sat;
        logic [WIDTH_OUT-1:0]  val;
        xs = {{(WW - WIDTH_IN){x[WIDTH_IN-1]}}, x};
        sh = '0;
        if (total == BIAS_T) begin
            wide = xs;
        end else if (total > BIAS_T) begin
            sh = total - BIAS_T;
            if (sh >= WIN_T) wide = x[WIDTH_IN-1] ? '1 : '0;
            else             wide = xs >>> sh;
        end else begin
            sh   = BIAS_T - total;
            wide = xs <<< sh;
        end
        sat = 1'b0;
        if (wide > MAXV) begin
            sat = 1'b1;
            val = MAXV[WIDTH_OUT-1:0];
        end else if (wide < MINV) begin
            sat = 1'b1;
            val = MINV[WIDTH_OUT-1:0];
        end else begin
            val = wide[WIDTH_OUT-1:0];
        end
        return {sat, val};
    endfunction

    assign re_res  = denorm(s1_re, s1_total);
    assign im_res  = denorm(s1_im, s1_total);
    assign sat_now = re_res[WIDTH_OUT] | im_res[WIDTH_OUT];
    assign s1_last = (s1_idx == LAST_IDX);

    // Frame position counter: advances only on accepted samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (din_valid) begin
            if (cnt == LAST_IDX) cnt <= '0;
            else                 cnt <= cnt + 1'b1;
        end
    end

    // Stage 1: capture mantissas, index sum and frame position.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_total <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_re    <= din_re;
                s1_im    <= din_im;
                s1_total <= {1'b0, index1} + {1'b0, index2};
                s1_idx   <= cnt;
            end
        end
    end

    // Stage 2: register shifted results, frame tags and the per-frame saturation flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            frame_sat  <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            dout_valid <= s1_valid;
            if (s1_valid) begin
                dout_re    <= re_res[WIDTH_OUT-1:0];
                dout_im    <= im_res[WIDTH_OUT-1:0];
                dout_first <= (s1_idx == '0);
                dout_last  <= s1_last;
                frame_sat  <= s1_last & (sticky | sat_now);
                // The sticky bit restarts with every frame, so the next frame's
                // flag only reflects its own samples.
                sticky     <= s1_last ? 1'b0 : (sticky | sat_now);
            end else begin
                dout_first <= 1'b0;
                dout_last  <= 1'b0;
                frame_sat  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: directed gain/saturation cases, framing
// with gaps, mid-frame reset and a random regression against an arithmetic model.
module tb_cbfp_denorm;

    localparam int WIDTH_IN  = 13;
    localparam int WIDTH_OUT = 23;
    localparam int IDX_W     = 6;
    localparam int BIAS      = 12;
    localparam int N         = 512;

    localparam longint OMAX = (longint'(1) <<< (WIDTH_OUT - 1)) - 1;
    localparam longint OMIN = -(longint'(1) <<< (WIDTH_OUT - 1));

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        din_valid = 1'b0;
    logic signed [WIDTH_IN-1:0]  din_re = '0;
    logic signed [WIDTH_IN-1:0]  din_im = '0;
    logic        [IDX_W-1:0]     index1 = '0;
    logic        [IDX_W-1:0]     index2 = '0;
    logic                        dout_valid;
    logic signed [WIDTH_OUT-1:0] dout_re;
    logic signed [WIDTH_OUT-1:0] dout_im;
    logic                        dout_first;
    logic                        dout_last;
    logic                        frame_sat;

    cbfp_denorm #(
        .WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .IDX_W(IDX_W), .BIAS(BIAS), .N(N)
    ) dut (
        .clk(clk), .rstn(rstn), .din_valid(din_valid),
        .din_re(din_re), .din_im(din_im), .index1(index1), .index2(index2),
        .dout_valid(dout_valid), .dout_re(dout_re), .dout_im(dout_im),
        .dout_first(dout_first), .dout_last(dout_last), .frame_sat(frame_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     first;
        bit     last;
        bit     fsat;
        int     tag;
    } exp_t;

    exp_t   q[$];
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_in = 0;
    int     n_out = 0;
    int     cyc = 0;
    int     pos = 0;
    bit     frame_any = 0;
    longint held_re = 0;
    longint held_im = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference: x * 2^(BIAS - total) with floor rounding, then clamp.
    function automatic longint scale(input int x, input int total, output bit sat);
        longint r;
        longint d;
        int     sh;
        if (total <= BIAS) begin
            r = longint'(x) * (longint'(1) <<< (BIAS - total));
        end else begin
            sh = total - BIAS;
            if (sh > 40) sh = 40;
            d = longint'(1) <<< sh;
            r = longint'(x) / d;
            if ((longint'(x) % d) != 0 && x < 0) r = r - 1;
        end
        sat = 0;
        if (r > OMAX) begin r = OMAX; sat = 1; end
        if (r < OMIN) begin r = OMIN; sat = 1; end
        return r;
    endfunction

    task automatic drive(input int re, input int im, input int i1, input int i2,
                         input longint ere, input longint eim, input bit sat);
        exp_t e;
        @(posedge clk); #1;
        din_valid = 1'b1;
        din_re    = WIDTH_IN'(re);
        din_im    = WIDTH_IN'(im);
        index1    = IDX_W'(i1);
        index2    = IDX_W'(i2);
        e.re    = ere;
        e.im    = eim;
        e.first = (pos == 0);
        e.last  = (pos == N - 1);
        frame_any = frame_any | sat;
        e.fsat  = e.last ? frame_any : 1'b0;
        if (e.last) frame_any = 0;
        pos = (pos + 1) % N;
        e.tag = cyc + 1;
        q.push_back(e);
        n_in++;
    endtask

    task automatic send(input int re, input int im, input int i1, input int i2);
        longint vr, vi;
        bit     sr, si;
        vr = scale(re, i1 + i2, sr);
        vi = scale(im, i1 + i2, si);
        drive(re, im, i1, i2, vr, vi, sr | si);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_re    = WIDTH_IN'($urandom);
        din_im    = WIDTH_IN'($urandom);
        index1    = IDX_W'($urandom);
        index2    = IDX_W'($urandom);
    endtask

    task automatic send_rand(input bit allow_sat);
        int i1, i2;
        if (allow_sat && $urandom_range(0, 3) == 0) begin
            i1 = $urandom_range(0, 2);
            i2 = $urandom_range(0, 2);
        end else begin
            i1 = $urandom_range(1, 63);
            i2 = $urandom_range(1, 63);
        end
        send(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096, i1, i2);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rstn      = 1'b0;
        din_valid = 1'b0;
        q.delete();
        pos       = 0;
        frame_any = 0;
        held_re   = 0;
        held_im   = 0;
        repeat (cycles) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            check("rst_valid", longint'(dout_valid), 0);
            check("rst_re", longint'(dout_re), 0);
            check("rst_im", longint'(dout_im), 0);
            check("rst_tags", longint'({dout_first, dout_last, frame_sat}), 0);
        end else if (dout_valid) begin
            n_out++;
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("latency", longint'(cyc - e.tag), 1);
                check("dout_re", longint'(dout_re), e.re);
                check("dout_im", longint'(dout_im), e.im);
                check("dout_first", longint'(dout_first), longint'(e.first));
                check("dout_last", longint'(dout_last), longint'(e.last));
                check("frame_sat", longint'(frame_sat), longint'(e.fsat));
                held_re = e.re;
                held_im = e.im;
            end
        end else begin
            check("idle_tags", longint'({dout_first, dout_last, frame_sat}), 0);
            check("hold_re", longint'(dout_re), held_re);
            check("hold_im", longint'(dout_im), held_im);
        end
    end

    initial begin
        do_reset(3);
        idle();

        // Directed gain paths and boundaries.
        drive(100, -100, 5, 5, 400, -400, 0);
        drive(100, -100, 7, 7, 25, -25, 0);
        drive(100, -100, 6, 6, 100, -100, 0);
        drive(-1, 7, 40, 40, -1, 0, 0);
        drive(4095, -4096, 0, 0, 4194303, -4194304, 1);
        // Fill the rest of frame 0 without saturation; its last sample flags it.
        for (int i = 5; i < N; i++) send_rand(0);
        // Clean contiguous frame: frame_sat must drop back to 0.
        for (int i = 0; i < N; i++) send_rand(0);
        // Frame with random valid gaps and random saturation.
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) == 0) idle();
            send_rand(1);
        end
        repeat (4) idle();
        check("count_after_framing", longint'(n_out), longint'(n_in));

        // Mid-frame reset.
        for (int i = 0; i < 200; i++) send_rand(1);
        do_reset(4);
        idle();
        for (int i = 0; i < N; i++) send_rand(1);
        idle();

        // Random regression.
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) idle();
                send_rand(1);
            end
        end

        repeat (6) idle();
        check("queue_drained", longint'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
